fence_unit: RTL and testbench
=============================

Name: fence_unit

Overview:
- Sequential execution unit for memory-ordering instructions: FENCE (honours pred/succ), FENCE.TSO and FENCE.I.
- Sits beside the CSR functional unit; the issue stage hands it decoded MISCMEM ops.
- Drains the store buffer and outstanding loads, optionally writes back the data cache, invalidates the I-cache, and requests a pipeline flush before reporting completion to the scoreboard.

Parameters:
- TRANS_ID_BITS, 3: width of the scoreboard transaction id.
- DCACHE_WB, 1: 1 = write-back D-cache; FENCE.I performs the D-cache flush handshake. 0 = handshake skipped.
- TIMEOUT_CYCLES, 1024: cycle limit in DRAIN and DC_FLUSH before an error completion. 0 disables the timeout.
- CNT_BITS, 11: timeout counter width; must satisfy 2^CNT_BITS > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline kill of the in-flight fence
- fence_valid_i  in  1  issue request
- fence_ready_o  out  1  unit idle, can accept
- fence_op_i  in  2  00 FENCE, 01 FENCE_I, 10 FENCE_TSO, 11 illegal
- pred_i  in  4  predecessor set {I,O,R,W}
- succ_i  in  4  successor set {I,O,R,W}
- trans_id_i  in  TRANS_ID_BITS  scoreboard id
- sb_empty_i  in  1  store buffer empty
- ld_pending_i  in  1  loads outstanding
- dc_flush_req_o  out  1  D-cache write-back request (level)
- dc_flush_ack_i  in  1  D-cache write-back complete (1-cycle pulse)
- ic_flush_o  out  1  I-cache invalidate pulse
- flush_pipeline_o  out  1  refetch-after-fence pulse
- done_valid_o  out  1  completion pulse
- done_trans_id_o  out  TRANS_ID_BITS  id of completed fence
- done_ex_o  out  1  completion carries exception (illegal / timeout)

Behaviour:
- Clock/reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low.
- Reset values:
  - state = IDLE, counter = 0.
  - All outputs 0, except fence_ready_o = 1.
  - Latched op/pred/succ/id = 0.
- States: IDLE, DRAIN, DC_FLUSH, IC_FLUSH, DONE.
- Ready: fence_ready_o = (state == IDLE). Accept on fence_valid_i & fence_ready_o. Latch op, pred, succ, trans_id.
- Transitions from IDLE on accept:
  - op 11 -> DONE with ex = 1.
  - FENCE with pred == 0 or succ == 0 -> DONE (no-op).
  - Otherwise -> DRAIN.
- DRAIN wait condition:
  - need_st = pred.W | pred.O; need_ld = pred.R | pred.I.
  - FENCE_TSO and FENCE_I force need_st = need_ld = 1.
  - Condition met = (!need_st | sb_empty_i) & (!need_ld | !ld_pending_i), evaluated every cycle.
- DRAIN exit when condition met:
  - FENCE/FENCE_TSO -> DONE.
  - FENCE_I -> DC_FLUSH if DCACHE_WB, else IC_FLUSH.
- DC_FLUSH:
  - dc_flush_req_o = 1 for the whole state.
  - dc_flush_ack_i -> IC_FLUSH next cycle.
  - An ack in the first DC_FLUSH cycle is legal.
- IC_FLUSH: ic_flush_o = 1 for exactly one cycle -> DONE.
- DONE (one cycle, then IDLE):
  - done_valid_o = 1, done_trans_id_o = latched id, done_ex_o = latched ex.
  - flush_pipeline_o = 1 iff op = FENCE_I and ex = 0.
- Latency (from the cycle after the accept edge, conditions already met):
  - No-op/illegal: done in the next cycle.
  - FENCE: done 2 cycles after accept.
  - FENCE_I with DCACHE_WB and immediate ack: 4 cycles.
- Timeout:
  - Counter clears on entering DRAIN or DC_FLUSH and increments each cycle in those states.
  - Counter == TIMEOUT_CYCLES-1 while still waiting -> DONE with ex = 1.
  - No ic_flush_o and no flush_pipeline_o on timeout.
  - In DC_FLUSH, a timeout drops dc_flush_req_o.
- flush_i:
  - In IDLE: ignored.
  - Same cycle as an accept: the accept is dropped; state stays IDLE.
  - In DRAIN, IC_FLUSH or DONE: abort to IDLE next cycle. No done_valid_o after the abort cycle; an ic_flush_o already pulsed stands.
  - In DC_FLUSH: keep dc_flush_req_o until ack (or timeout), then go to IDLE silently. No write-back request is ever abandoned mid-handshake.
- Back-to-back: a new fence is accepted in the cycle after DONE (IDLE). No pipelining of two fences.

Test Plan:
- FENCE pred=0011 (RW), succ=0011, sb_empty_i=0 for 5 cycles then 1, ld_pending_i=0 -> done_valid_o exactly 1 cycle after sb_empty_i rises; done_ex_o=0; no ic_flush_o or flush_pipeline_o.
- FENCE pred=0000 id=5 -> done_valid_o next cycle, done_trans_id_o=5; DRAIN never entered even with sb_empty_i=0.
- FENCE_I, DCACHE_WB=1, ack 3 cycles after req -> dc_flush_req_o high 3 cycles, then ic_flush_o 1 cycle, then done_valid_o and flush_pipeline_o together; fence_ready_o=0 throughout.
- FENCE_TSO, TIMEOUT_CYCLES=8, sb_empty_i stuck 0 -> done_valid_o with done_ex_o=1 in cycle 8 after DRAIN entry; flush_pipeline_o=0.
- op=11 id=2 -> next cycle done_valid_o=1, done_ex_o=1, done_trans_id_o=2.
- flush_i during DRAIN -> IDLE next cycle, no done_valid_o. flush_i during DC_FLUSH -> dc_flush_req_o held until ack, then IDLE, no ic_flush_o. Async reset mid-DC_FLUSH -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fence_unit.sv
// fence_unit: sequential executor for FENCE, FENCE.TSO and FENCE.I.
// Drains the store buffer and outstanding loads, optionally writes back the
// D-cache, invalidates the I-cache and requests a refetch before reporting
// completion to the scoreboard.
module fence_unit #(
    parameter int TRANS_ID_BITS  = 3,
    parameter bit DCACHE_WB      = 1'b1,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_BITS       = 11
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     fence_valid_i,
    output logic                     fence_ready_o,
    input  logic [1:0]               fence_op_i,
    input  logic [3:0]               pred_i,
    input  logic [3:0]               succ_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    input  logic                     sb_empty_i,
    input  logic                     ld_pending_i,
    output logic                     dc_flush_req_o,
    input  logic                     dc_flush_ack_i,
    output logic                     ic_flush_o,
    output logic                     flush_pipeline_o,
    output logic                     done_valid_o,
    output logic [TRANS_ID_BITS-1:0] done_trans_id_o,
    output logic                     done_ex_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_DRAIN, S_DC_FLUSH, S_IC_FLUSH, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_FENCE     = 2'b00,
        OP_FENCE_I   = 2'b01,
        OP_FENCE_TSO = 2'b10,
        OP_ILLEGAL   = 2'b11
    } op_e;

    // Last counter value before giving up; unused when the timeout is disabled.
    localparam logic [CNT_BITS-1:0] TO_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

    state_e                   r_state;
    op_e                      r_op;
    logic [3:0]               r_pred;
    logic [TRANS_ID_BITS-1:0] r_id;
    logic                     r_ex;
    logic                     r_abort;
    logic [CNT_BITS-1:0]      r_cnt;

    state_e                   w_state_nxt;
    logic                     w_ex_nxt;
    logic                     w_abort_nxt;
    logic [CNT_BITS-1:0]      w_cnt_nxt;
    logic                     w_accept;
    logic                     w_need_st;
    logic                     w_need_ld;
    logic                     w_drained;
    logic                     w_timeout;
    logic                     w_kill_dc;

    // A flush in the same cycle as a request drops that request.
    assign w_accept = fence_valid_i && (r_state == S_IDLE) && !flush_i;

    // pred = {I,O,R,W}: stores cover W/O, loads cover R/I; TSO and FENCE.I drain both.
    assign w_need_st = r_pred[0] | r_pred[2] | (r_op != OP_FENCE);
    assign w_need_ld = r_pred[1] | r_pred[3] | (r_op != OP_FENCE);
    assign w_drained = (!w_need_st || sb_empty_i) && (!w_need_ld || !ld_pending_i);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);

    // A kill seen at any point during the write-back handshake is remembered.
    assign w_kill_dc = r_abort | flush_i;

    // State register plus the operands latched at accept time.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_op    <= OP_FENCE;
            r_pred  <= '0;
            r_id    <= '0;
            r_ex    <= 1'b0;
            r_abort <= 1'b0;
            r_cnt   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_state <= w_state_nxt;
            r_ex    <= w_ex_nxt;
            r_abort <= w_abort_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_op   <= op_e'(fence_op_i);
                r_pred <= pred_i;
                r_id   <= trans_id_i;
            end
        end
    end

    // Next-state, exception flag, abort flag and timeout counter.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        w_state_nxt = r_state;
        w_ex_nxt    = r_ex;
        w_abort_nxt = r_abort;
        unique case (r_state)
            S_IDLE: begin
                w_abort_nxt = 1'b0;
                if (w_accept) begin
                    w_ex_nxt = 1'b0;
                    if (fence_op_i == OP_ILLEGAL) begin
                        w_state_nxt = S_DONE;
                        w_ex_nxt    = 1'b1;
                    end else if (fence_op_i == OP_FENCE &&
                                 (pred_i == 4'b0000 || succ_i == 4'b0000)) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (flush_i) begin
                    w_state_nxt = S_IDLE;
                end else if (w_drained) begin
                    if (r_op == OP_FENCE_I) begin
                        w_state_nxt = DCACHE_WB ? S_DC_FLUSH : S_IC_FLUSH;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_DONE;
                    w_ex_nxt    = 1'b1;
                end
            end
            S_DC_FLUSH: begin
                // The write-back handshake always runs to ack or timeout.
                w_abort_nxt = w_kill_dc;
                if (dc_flush_ack_i) begin
                    w_state_nxt = w_kill_dc ? S_IDLE : S_IC_FLUSH;
                end else if (w_timeout) begin
                    w_state_nxt = w_kill_dc ? S_IDLE : S_DONE;
                    w_ex_nxt    = 1'b1;
                end
            end
            S_IC_FLUSH: begin
                w_state_nxt = flush_i ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Counter restarts on entry to a waiting state and counts while there.
        if (w_state_nxt != r_state &&
            (w_state_nxt == S_DRAIN || w_state_nxt == S_DC_FLUSH)) begin
            w_cnt_nxt = '0;
        end else if (r_state == S_DRAIN || r_state == S_DC_FLUSH) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else begin
            w_cnt_nxt = '0;
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        fence_ready_o    = (r_state == S_IDLE);
        dc_flush_req_o   = (r_state == S_DC_FLUSH);
        ic_flush_o       = (r_state == S_IC_FLUSH);
        done_valid_o     = (r_state == S_DONE);
        done_trans_id_o  = (r_state == S_DONE) ? r_id : '0;
        done_ex_o        = (r_state == S_DONE) && r_ex;
        flush_pipeline_o = (r_state == S_DONE) && (r_op == OP_FENCE_I) && !r_ex;
    end

endmodule

// File: tb/tb_fence_unit.sv
// tb_fence_unit: directed stimulus with a completion scoreboard.
// Issued fences that should complete push {id, ex, flush_pipeline} into a
// queue; a negedge monitor pops and compares on every done_valid_o.
module tb_fence_unit;

    localparam int IDW = 3;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic           flush_i = 1'b0;
    logic           fence_valid_i = 1'b0;
    logic           fence_ready_o;
    logic [1:0]     fence_op_i = 2'b00;
    logic [3:0]     pred_i = 4'b0000;
    logic [3:0]     succ_i = 4'b0000;
    logic [IDW-1:0] trans_id_i = '0;
    logic           sb_empty_i = 1'b1;
    logic           ld_pending_i = 1'b0;
    logic           dc_flush_req_o;
    logic           dc_flush_ack_i = 1'b0;
    logic           ic_flush_o;
    logic           flush_pipeline_o;
    logic           done_valid_o;
    logic [IDW-1:0] done_trans_id_o;
    logic           done_ex_o;

    fence_unit #(
        .TRANS_ID_BITS  (IDW),
        .DCACHE_WB      (1'b1),
        .TIMEOUT_CYCLES (8),
        .CNT_BITS       (4)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .flush_i          (flush_i),
        .fence_valid_i    (fence_valid_i),
        .fence_ready_o    (fence_ready_o),
        .fence_op_i       (fence_op_i),
        .pred_i           (pred_i),
        .succ_i           (succ_i),
        .trans_id_i       (trans_id_i),
        .sb_empty_i       (sb_empty_i),
        .ld_pending_i     (ld_pending_i),
        .dc_flush_req_o   (dc_flush_req_o),
        .dc_flush_ack_i   (dc_flush_ack_i),
        .ic_flush_o       (ic_flush_o),
        .flush_pipeline_o (flush_pipeline_o),
        .done_valid_o     (done_valid_o),
        .done_trans_id_o  (done_trans_id_o),
        .done_ex_o        (done_ex_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           ex;
        logic           fp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   total  = 0;
    int   bad    = 0;
    int   n_done = 0;
    int   n_ic   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Present one request for one cycle; optionally record its expected completion.
    task automatic issue(input logic [1:0] op, input logic [3:0] pr, input logic [3:0] su,
                         input logic [IDW-1:0] id, input bit expect_done,
                         input bit ex, input bit fp);
        exp_t e;
        fence_valid_i = 1'b1;
        fence_op_i    = op;
        pred_i        = pr;
        succ_i        = su;
        trans_id_i    = id;
        if (expect_done) begin
            e.id = id;
            e.ex = ex;
            e.fp = fp;
            exp_q.push_back(e);
        end
        tick();
        fence_valid_i = 1'b0;
    endtask

    // Monitor: scoreboard comparison on every completion, plus I-cache pulse count.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (ic_flush_o) n_ic++;
            if (done_valid_o) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sb_id", 32'(done_trans_id_o), 32'(mon_e.id));
                    check("sb_ex", 32'(done_ex_o), 32'(mon_e.ex));
                    check("sb_flush_pipe", 32'(flush_pipeline_o), 32'(mon_e.fp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        #2;
        check("rst_ready", 32'(fence_ready_o), 32'd1);
        check("rst_outs", {26'd0, dc_flush_req_o, ic_flush_o, flush_pipeline_o,
                           done_valid_o, done_ex_o, 1'b0}, 32'd0);
        check("rst_id", 32'(done_trans_id_o), 32'd0);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();

        // FENCE RW,RW with store buffer busy for 5 cycles
        sb_empty_i = 1'b0;
        issue(2'b00, 4'b0011, 4'b0011, 3'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("t1_wait_done", 32'(done_valid_o), 32'd0);
            check("t1_wait_ready", 32'(fence_ready_o), 32'd0);
            tick();
        end
        sb_empty_i = 1'b1;
        check("t1_pre_done", 32'(done_valid_o), 32'd0);
        tick();
        check("t1_done", 32'(done_valid_o), 32'd1);
        check("t1_no_ic", 32'(ic_flush_o), 32'd0);
        tick();
        check("t1_ready_after", 32'(fence_ready_o), 32'd1);

        // FENCE with empty pred is a no-op, even with stores pending
        sb_empty_i = 1'b0;
        issue(2'b00, 4'b0000, 4'b0011, 3'd5, 1'b1, 1'b0, 1'b0);
        check("t2_done_next", 32'(done_valid_o), 32'd1);
        check("t2_id", 32'(done_trans_id_o), 32'd5);
        tick();
        check("t2_idle", 32'(fence_ready_o), 32'd1);

        // Illegal op back-to-back, id 2
        issue(2'b11, 4'b1111, 4'b1111, 3'd2, 1'b1, 1'b1, 1'b0);
        check("t5_done", 32'(done_valid_o), 32'd1);
        check("t5_ex", 32'(done_ex_o), 32'd1);
        tick();

        // FENCE.I with write-back, ack arriving in the third request cycle
        sb_empty_i = 1'b1;
        issue(2'b01, 4'b0000, 4'b0000, 3'd3, 1'b1, 1'b0, 1'b1);
        check("t3_drain_noreq", 32'(dc_flush_req_o), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t3_req", 32'(dc_flush_req_o), 32'd1);
            check("t3_busy", 32'(fence_ready_o), 32'd0);
            if (i == 2) dc_flush_ack_i = 1'b1;
            tick();
            dc_flush_ack_i = 1'b0;
        end
        check("t3_ic", 32'(ic_flush_o), 32'd1);
        check("t3_req_low", 32'(dc_flush_req_o), 32'd0);
        check("t3_busy_ic", 32'(fence_ready_o), 32'd0);
        tick();
        check("t3_done", 32'(done_valid_o), 32'd1);
        check("t3_fp", 32'(flush_pipeline_o), 32'd1);
        check("t3_ic_once", 32'(ic_flush_o), 32'd0);
        tick();

        // FENCE.TSO with the store buffer stuck: timeout after 8 DRAIN cycles
        sb_empty_i = 1'b0;
        issue(2'b10, 4'b0000, 4'b0000, 3'd4, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("t4_wait", 32'(done_valid_o), 32'd0);
            tick();
        end
        check("t4_done", 32'(done_valid_o), 32'd1);
        check("t4_ex", 32'(done_ex_o), 32'd1);
        tick();

        // Request with flush in the same cycle is dropped
        flush_i = 1'b1;
        issue(2'b10, 4'b1111, 4'b1111, 3'd6, 1'b0, 1'b0, 1'b0);
        flush_i = 1'b0;
        check("t6a_still_idle", 32'(fence_ready_o), 32'd1);
        tick();

        // flush_i during DRAIN aborts silently
        issue(2'b10, 4'b0000, 4'b0000, 3'd6, 1'b0, 1'b0, 1'b0);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("t6_idle", 32'(fence_ready_o), 32'd1);
        check("t6_no_done", 32'(done_valid_o), 32'd0);
        repeat (3) tick();

        // flush_i during DC_FLUSH keeps the request until ack, then idles
        sb_empty_i = 1'b1;
        issue(2'b01, 4'b0000, 4'b0000, 3'd7, 1'b0, 1'b0, 1'b0);
        tick();
        check("t7_req0", 32'(dc_flush_req_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("t7_req_held", 32'(dc_flush_req_o), 32'd1);
        tick();
        check("t7_req_held2", 32'(dc_flush_req_o), 32'd1);
        dc_flush_ack_i = 1'b1;
        tick();
        dc_flush_ack_i = 1'b0;
        check("t7_idle", 32'(fence_ready_o), 32'd1);
        check("t7_no_ic", 32'(ic_flush_o), 32'd0);
        tick();
        check("t7_no_done", 32'(done_valid_o), 32'd0);

        // Asynchronous reset in the middle of DC_FLUSH
        issue(2'b01, 4'b0000, 4'b0000, 3'd1, 1'b0, 1'b0, 1'b0);
        tick();
        check("t9_req_before", 32'(dc_flush_req_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t9_req_rst", 32'(dc_flush_req_o), 32'd0);
        check("t9_ready_rst", 32'(fence_ready_o), 32'd1);
        check("t9_outs_rst", {27'd0, ic_flush_o, flush_pipeline_o, done_valid_o,
                              done_ex_o, 1'b0}, 32'd0);
        tick();
        rst_ni = 1'b1;
        repeat (2) tick();
        check("t9_idle_after", 32'(fence_ready_o), 32'd1);

        // End-of-run bookkeeping
        check("sb_queue_empty", 32'(exp_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'd5);
        check("ic_count", 32'(n_ic), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
